md5_padder: RTL and testbench
=============================

# md5_padder

Streaming MD5 message padder. Accepts a message as a stream of byte beats, BYTES_PER_BEAT wide. Emits complete 512-bit MD5 input blocks carrying the standard padding: a 0x80 marker, zero fill, and the 64-bit little-endian bit length. It sits between the byte source and the md5 compression core. It replaces the single-byte `start`/`data_in` feed with a handshaked, width-parametrised front end that handles arbitrary message length, including the empty message.

## Interface
- BYTES_PER_BEAT, default 1: input bytes per beat. Legal values are 1, 2, 4, 8; the value must divide 64.
- CNT_W, localparam: $clog2(BYTES_PER_BEAT+1), the width of in_bytes.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that opens a new message. It is honoured only in IDLE.
- data_in  in  8*BYTES_PER_BEAT  message bytes. Byte i is data_in[8i+7:8i] and is earlier in the message than byte i+1.
- in_valid  in  1  beat present.
- in_last  in  1  this beat is the final beat of the message.
- in_bytes  in  CNT_W  count of valid low-order bytes on the last beat. Legal range is 0..BYTES_PER_BEAT. The value is ignored when in_last=0.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- blk_data  out  512  block. Message byte k of the block is at blk_data[8k+7:8k].
- blk_valid  out  1  block present.
- blk_last  out  1  final block of the message; qualified by blk_valid.
- blk_ready  in  1  consumer accepts the block when blk_valid & blk_ready.
- busy  out  1  high in every state except IDLE.

## Operation
- Internal state:
  - 64-byte buffer `buf`.
  - Byte pointer `ptr`, 0..64.
  - 61-bit message byte counter `len`. The bit length is {len,3'b000}, modulo 2^64.
  - Flag `need_pad` records that an extra padding block is owed.
- States: IDLE, FILL, EMIT, PADBLK.
- IDLE:
  - in_ready=0.
  - start moves the block to FILL and clears ptr, len and need_pad.
- FILL:
  - in_ready=1.
  - A non-last beat writes BYTES_PER_BEAT bytes at ptr and advances ptr and len by BYTES_PER_BEAT.
  - If ptr reaches 64: load blk_data=buf, set blk_last=0, go to EMIT, then return to FILL.
- Last beat, n = in_bytes:
  - Write n bytes, then 0x80 at ptr+n, then zeros up to byte 63. len += n.
  - If ptr+n ≤ 55: place the bit length at bytes 56..63, little-endian. blk_last=1.
  - Otherwise (ptr+n in 56..63): no length field. blk_last=0, need_pad=1.
  - If ptr+n = 64: the block holds data only, blk_last=0, need_pad=1, and the 0x80 goes in the pad block.
  - Go to EMIT.
- EMIT:
  - blk_valid=1. blk_data and blk_last are held stable until blk_ready.
  - On the handshake:
    - If blk_last, go to IDLE.
    - Else if need_pad, go to PADBLK.
    - Else go to FILL with ptr=0.
- PADBLK (one cycle):
  - Build the pad block: 0x80 at byte 0 only if the marker was not yet placed, zeros elsewhere, length at bytes 56..63.
  - blk_last=1. Go to EMIT.
- Boundary rules:
  - start outside IDLE is ignored.
  - in_valid in IDLE, EMIT or PADBLK is not accepted because in_ready=0.
  - start and in_valid in the same IDLE cycle: only start is taken.
  - in_bytes > BYTES_PER_BEAT is illegal. An assertion fires in simulation.
  - Reset mid-message discards all state, with no partial block emitted.

## Timing
- Reset values:
  - in_ready=0, blk_valid=0, blk_last=0, busy=0, blk_data=0.
  - State is IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: blk_valid rises one cycle after the beat that completes a block.
- A PADBLK block appears one cycle after the preceding EMIT handshake.
- Throughput: at most one block per 64/BYTES_PER_BEAT + 1 cycles when blk_ready is held high.
- IDLE is re-entered the cycle after the final handshake; the next start is accepted in that cycle.

## Structure
- Package `md5_pkg` holds:
  - The state enum.
  - BLOCK_BYTES=64, LEN_OFFSET=56, PAD_BYTE=8'h80.
  - A function `put_len(block, bitlen)` shared with the md5 core bench.
- No sub-module is warranted. The byte-lane write, the pad mask and the length insertion are generate loops inside md5_padder.

## Test plan
- **Empty message**, BYTES_PER_BEAT=1: start, then one beat with in_last=1, in_bytes=0.
  - Required: one block, byte0=0x80, all other bytes 0x00, blk_last=1.
- **"hello="**, BYTES_PER_BEAT=1: bytes 68 65 6c 6c 6f 3d, last on 3d.
  - Required: block bytes 0..6 = 68 65 6c 6c 6f 3d 80, byte56=0x30, all others zero, blk_last=1.
- **56-byte message** of 0x61:
  - Required, block 1: bytes 0..55 = 0x61, byte56=0x80, blk_last=0.
  - Required, block 2: zeros except byte56=0xC0 and byte57=0x01, blk_last=1.
- **64-byte message**, BYTES_PER_BEAT=4, last beat with in_bytes=4:
  - Required, block 1: data only, blk_last=0.
  - Required, block 2: byte0=0x80, byte57=0x02, blk_last=1.
- **Backpressure**: hold blk_ready=0 for 5 cycles during EMIT.
  - Required: blk_data, blk_valid and blk_last stay stable and in_ready=0 throughout; the block transfers exactly once.
- **Reset mid-message**: rst_n low after 10 bytes, then the "hello=" sequence.
  - Required: all outputs return to their reset values immediately; the "hello=" sequence then produces exactly the block from the "hello=" scenario.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 front end: padder state encoding, block
// geometry constants and the length-field helper also used by the core bench.
package md5_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_EMIT   = 2'd2,
      ST_PADBLK = 2'd3
   } state_t;

   localparam int          BLOCK_BYTES = 64;
   localparam int          LEN_OFFSET  = 56;
   localparam logic [7:0]  PAD_BYTE    = 8'h80;

   // Overwrites bytes 56..63 with the 64-bit bit length, least significant byte first.
   function automatic logic [511:0] put_len(input logic [511:0] block, input logic [63:0] bitlen);
      logic [511:0] b;
      b = block;
      b[8*LEN_OFFSET +: 64] = bitlen;
      return b;
   endfunction

endpackage

// File: rtl/md5_padder.sv
// Streaming MD5 padder: packs handshaked byte beats into 512-bit blocks and
// appends the 0x80 marker, zero fill and little-endian bit length.
//
// state   | meaning
// IDLE    | waiting for start, no beats accepted
// FILL    | accepting beats into the block buffer
// EMIT    | block presented on blk_data until blk_ready
// PADBLK  | one cycle building the trailing length-only block
module md5_padder
   import md5_pkg::*;
#(
   parameter  int BYTES_PER_BEAT = 1,
   localparam int CNT_W          = $clog2(BYTES_PER_BEAT + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [8*BYTES_PER_BEAT-1:0] data_in,
   input  logic                        in_valid,
   input  logic                        in_last,
   input  logic [CNT_W-1:0]            in_bytes,
   output logic                        in_ready,
   output logic [511:0]                blk_data,
   output logic                        blk_valid,
   output logic                        blk_last,
   input  logic                        blk_ready,
   output logic                        busy
);

   state_t        state, state_next;
   logic [511:0]  buf_q;
   logic [6:0]    ptr;
   logic [60:0]   len;
   logic          need_pad;
   logic          marker_owed;

   logic [6:0]    cnt;
   logic [6:0]    fill_end;
   logic [60:0]   len_sum;
   logic          fits_len;
   logic          blk_full;
   logic [511:0]  merged;
   logic [511:0]  pad_block;

   assign cnt      = in_last ? 7'(in_bytes) : 7'(BYTES_PER_BEAT);
   assign fill_end = ptr + cnt;
   assign len_sum  = len + 61'(cnt);
   assign fits_len = fill_end <= 7'(LEN_OFFSET - 1);
   assign blk_full = fill_end == 7'(BLOCK_BYTES);

   // Per-byte merge of buffered bytes, the current beat, and the marker/zero tail.
   for (genvar j = 0; j < BLOCK_BYTES; j++) begin : g_byte
      logic [6:0] off;
      logic [7:0] lane;
      logic [7:0] mbyte;

      assign off = 7'(j) - ptr;

      always_comb begin
         lane = 8'h00;
         for (int l = 0; l < BYTES_PER_BEAT; l++) begin
            if (off == 7'(l)) lane = data_in[8*l +: 8];
         end
      end

      always_comb begin
         if (7'(j) < ptr)                       mbyte = buf_q[8*j +: 8];
         else if (7'(j) < fill_end)             mbyte = lane;
         else if (in_last && 7'(j) == fill_end) mbyte = PAD_BYTE;
         else                                   mbyte = 8'h00;
      end

      assign merged[8*j +: 8] = mbyte;
   end

   assign pad_block = put_len({504'b0, (marker_owed ? PAD_BYTE : 8'h00)}, {len, 3'b000});

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:   if (start) state_next = ST_FILL;
         ST_FILL:   if (in_valid && (in_last || blk_full)) state_next = ST_EMIT;
         ST_EMIT: begin
            if (blk_ready) begin
               if (blk_last)      state_next = ST_IDLE;
               else if (need_pad) state_next = ST_PADBLK;
               else               state_next = ST_FILL;
            end
         end
         ST_PADBLK: state_next = ST_EMIT;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         in_ready    <= 1'b0;
         blk_valid   <= 1'b0;
         blk_last    <= 1'b0;
         busy        <= 1'b0;
         blk_data    <= '0;
         buf_q       <= '0;
         ptr         <= '0;
         len         <= '0;
         need_pad    <= 1'b0;
         marker_owed <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= state_next == ST_FILL;
         blk_valid <= state_next == ST_EMIT;
         busy      <= state_next != ST_IDLE;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  ptr         <= '0;
                  len         <= '0;
                  need_pad    <= 1'b0;
                  marker_owed <= 1'b0;
               end
            end
            ST_FILL: begin
               if (in_valid) begin
                  buf_q <= merged;
                  ptr   <= fill_end;
                  len   <= len_sum;
                  if (in_last) begin
                     blk_data    <= fits_len ? put_len(merged, {len_sum, 3'b000}) : merged;
                     blk_last    <= fits_len;
                     need_pad    <= !fits_len;
                     marker_owed <= blk_full;
                  end else if (blk_full) begin
                     blk_data <= merged;
                     blk_last <= 1'b0;
                  end
               end
            end
            ST_EMIT: begin
               if (blk_ready) begin
                  blk_last <= 1'b0;
                  if (!blk_last && !need_pad) ptr <= '0;
               end
            end
            ST_PADBLK: begin
               blk_data    <= pad_block;
               blk_last    <= 1'b1;
               need_pad    <= 1'b0;
               marker_owed <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   a_in_bytes_legal: assert property (@(posedge clk) disable iff (!rst_n)
      (state == ST_FILL && in_valid && in_last) |-> (int'(in_bytes) <= BYTES_PER_BEAT));

endmodule

// File: tb/tb_md5_padder.sv
// Self-checking bench for md5_padder: directed table plus randomized messages
// compared against a byte-queue padding model.
module tb_md5_padder;

   localparam int BPB = 4;
   localparam int CW  = $clog2(BPB + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [8*BPB-1:0]  data_in = '0;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic [CW-1:0]     in_bytes = '0;
   logic              in_ready;
   logic [511:0]      blk_data;
   logic              blk_valid;
   logic              blk_last;
   logic              blk_ready = 1'b0;
   logic              busy;

   int checks = 0;
   int errors = 0;

   logic [511:0] rx_data[$];
   bit           rx_last[$];
   logic [511:0] exp_data[$];
   bit           exp_last[$];
   bit           ready_rand = 1'b0;
   bit           ready_hold = 1'b0;

   typedef struct {
      int         len;
      int         nblk;
      logic [7:0] b56;
      logic [7:0] b57;
   } vec_t;

   always #5 clk = ~clk;

   md5_padder #(.BYTES_PER_BEAT(BPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_bytes  (in_bytes),
      .in_ready  (in_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_last  (blk_last),
      .blk_ready (blk_ready),
      .busy      (busy)
   );

   initial begin
      forever begin
         @(posedge clk);
         #1;
         blk_ready = ready_hold ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   always @(negedge clk) begin
      if (rst_n && blk_valid && blk_ready) begin
         rx_data.push_back(blk_data);
         rx_last.push_back(blk_last);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   // Reference: standard MD5 padding on the whole message, then split into blocks.
   task automatic build_expected(input logic [7:0] msg[$]);
      logic [7:0]   p[$];
      logic [63:0]  bitlen;
      logic [511:0] blk;
      int           nb;
      p = msg;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bitlen = 64'(msg.size()) * 64'd8;
      for (int i = 0; i < 8; i++) p.push_back(bitlen[8*i +: 8]);
      nb = p.size() / 64;
      exp_data.delete();
      exp_last.delete();
      for (int b = 0; b < nb; b++) begin
         blk = '0;
         for (int k = 0; k < 64; k++) blk[8*k +: 8] = p[64*b + k];
         exp_data.push_back(blk);
         exp_last.push_back(b == nb - 1);
      end
   endtask

   task automatic send_msg(input logic [7:0] msg[$], input bit gaps, input int abort_after);
      int idx, nbeats, budget, n;
      bit done, last, rdy;
      idx = 0; nbeats = 0; budget = 2000; done = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_bytes = '0;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      while (!done) begin
         n = msg.size() - idx;
         last = (n <= BPB);
         if (!last) n = BPB;
         in_valid = gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1;
         in_last  = last;
         in_bytes = CW'(n);
         for (int l = 0; l < BPB; l++) data_in[8*l +: 8] = (l < n) ? msg[idx + l] : 8'($urandom);
         start = gaps ? 1'($urandom_range(0, 7) == 0) : 1'b0;
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (in_valid && rdy) begin
            idx += n;
            nbeats++;
            if (last) done = 1'b1;
         end
         #1;
         if (abort_after >= 0 && nbeats == abort_after) break;
         budget--;
         if (budget == 0) begin
            timeout("send_budget");
            break;
         end
      end
      in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
      if (done) begin
         @(negedge clk);
         check("latency_blk_valid", blk_valid, 1);
      end
   endtask

   task automatic wait_blocks(input int nexp);
      int cyc;
      cyc = 0;
      while (rx_data.size() < nexp && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      if (rx_data.size() < nexp) timeout("wait_blocks");
      @(negedge clk);
      check("idle_after_last", busy, 0);
      repeat (5) @(negedge clk);
      check("block_count", rx_data.size(), nexp);
   endtask

   task automatic compare_model(input string name);
      for (int i = 0; i < exp_data.size() && i < rx_data.size(); i++) begin
         check({name, "_data"}, rx_data[i], exp_data[i]);
         check({name, "_last"}, rx_last[i], exp_last[i]);
      end
   endtask

   task automatic run_msg(input logic [7:0] msg[$], input bit gaps, input string name);
      rx_data.delete();
      rx_last.delete();
      ready_rand = gaps;
      build_expected(msg);
      send_msg(msg, gaps, -1);
      wait_blocks(exp_data.size());
      compare_model(name);
      ready_rand = 1'b0;
   endtask

   function automatic logic [511:0] hello_block();
      logic [511:0] b;
      logic [7:0]   hb[7];
      hb = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h3d, 8'h80};
      b = '0;
      for (int i = 0; i < 7; i++) b[8*i +: 8] = hb[i];
      b[8*56 +: 8] = 8'h30;
      return b;
   endfunction

   initial begin
      vec_t         tbl[9];
      logic [7:0]   msg[$];
      logic [7:0]   hello[$];
      logic [511:0] snap_data, b;
      logic         snap_last;
      int           cyc;

      tbl = '{
         '{0,   1, 8'h00, 8'h00},
         '{6,   1, 8'h30, 8'h00},
         '{55,  1, 8'hB8, 8'h01},
         '{56,  2, 8'hC0, 8'h01},
         '{63,  2, 8'hF8, 8'h01},
         '{64,  2, 8'h00, 8'h02},
         '{119, 2, 8'hB8, 8'h03},
         '{120, 3, 8'hC0, 8'h03},
         '{128, 3, 8'h00, 8'h04}
      };
      hello = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h3d};

      #12;
      check("rst_in_ready", in_ready, 0);
      check("rst_blk_valid", blk_valid, 0);
      check("rst_blk_last", blk_last, 0);
      check("rst_busy", busy, 0);
      check("rst_blk_data", blk_data, '0);
      rst_n = 1'b1;

      // empty message
      msg.delete();
      run_msg(msg, 1'b0, "empty");
      b = '0;
      b[7:0] = 8'h80;
      if (rx_data.size() > 0) begin
         check("empty_block", rx_data[0], b);
         check("empty_last", rx_last[0], 1);
      end

      // hello=
      run_msg(hello, 1'b0, "hello");
      if (rx_data.size() > 0) check("hello_block", rx_data[0], hello_block());

      // length table, data from $urandom
      for (int t = 0; t < 9; t++) begin
         msg.delete();
         for (int i = 0; i < tbl[t].len; i++) msg.push_back(8'($urandom));
         run_msg(msg, 1'b0, "table");
         check("table_nblk", rx_data.size(), tbl[t].nblk);
         if (rx_data.size() > 0) begin
            b = rx_data[rx_data.size() - 1];
            check("table_b56", b[8*56 +: 8], tbl[t].b56);
            check("table_b57", b[8*57 +: 8], tbl[t].b57);
            check("table_lastflag", rx_last[rx_last.size() - 1], 1);
         end
      end

      // 64-byte message: data-only block then marker-first pad block
      msg.delete();
      for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
      run_msg(msg, 1'b0, "m64");
      if (rx_data.size() == 2) begin
         b = rx_data[1];
         check("m64_pad_b0", b[7:0], 8'h80);
         check("m64_first_last", rx_last[0], 0);
      end

      // backpressure
      rx_data.delete();
      rx_last.delete();
      ready_hold = 1'b1;
      @(posedge clk);
      #2;
      send_msg(hello, 1'b0, -1);
      snap_data = blk_data;
      snap_last = blk_last;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_data", blk_data, snap_data);
         check("bp_valid", blk_valid, 1);
         check("bp_last", blk_last, snap_last);
         check("bp_in_ready", in_ready, 0);
      end
      check("bp_no_transfer", rx_data.size(), 0);
      ready_hold = 1'b0;
      wait_blocks(1);
      if (rx_data.size() > 0) check("bp_block", rx_data[0], hello_block());

      // reset mid-message
      msg.delete();
      for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
      rx_data.delete();
      rx_last.delete();
      send_msg(msg, 1'b0, 3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_blk_valid", blk_valid, 0);
      check("mid_rst_blk_last", blk_last, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_blk_data", blk_data, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_msg(hello, 1'b0, "post_rst_hello");
      if (rx_data.size() > 0) check("post_rst_block", rx_data[0], hello_block());

      // randomized messages with input gaps, stray starts and random backpressure
      for (int r = 0; r < 12; r++) begin
         msg.delete();
         cyc = $urandom_range(0, 200);
         for (int i = 0; i < cyc; i++) msg.push_back(8'($urandom));
         run_msg(msg, 1'b1, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
